// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   IF->ID pipeline stage backed by a DEPTH-entry instruction FIFO. Fetched
//   instructions that arrive while decode is stalled are queued in order
//   and presented to decode later without loss. A branch flush empties the
//   queue and the ID-side registers in a single cycle.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous reset, active-high (clears everything)
//   flush     : branch interception; drops queued/held instructions
//   if_valid  : if_pc/if_inst carry a fetched instruction this cycle
//   if_pc     : fetched pc
//   if_inst   : fetched instruction
//   if_ready  : FIFO not full (depends on stored state only)
//   id_stall  : decode cannot accept; ID-side outputs hold
//   id_valid  : id_pc/id_inst hold a real instruction
//   id_pc     : pc presented to decode
//   id_inst   : instruction presented to decode
//   count     : FIFO occupancy, excluding the ID-side register
//   overflow  : sticky flag, set when an if_valid was dropped while full
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         if_valid,
    input  logic [ADDR_WIDTH-1:0]        if_pc,
    input  logic [INST_WIDTH-1:0]        if_inst,
    output logic                         if_ready,
    input  logic                         id_stall,
    output logic                         id_valid,
    output logic [ADDR_WIDTH-1:0]        id_pc,
    output logic [INST_WIDTH-1:0]        id_inst,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_r [DEPTH];
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         wr_ptr_r;

    logic          empty_s;
    logic          full_s;
    logic          advance_s;
    logic          pop_s;
    logic          bypass_s;
    logic          push_s;
    logic          drop_s;
    logic [CW-1:0] count_nxt_s;

    // Per-cycle FIFO control decisions, all taken from pre-cycle state.
    always_comb begin
        empty_s   = (count == {CW{1'b0}});
        full_s    = (count == CW'(DEPTH));
        advance_s = !id_stall;
        pop_s     = advance_s && !empty_s;
        // With an empty queue and decode advancing, the fetch goes straight
        // into the ID registers and never occupies a FIFO slot.
        bypass_s  = advance_s && empty_s && if_valid;
        // Full check deliberately ignores a same-cycle pop.
        push_s    = if_valid && !full_s && !bypass_s;
        drop_s    = if_valid && full_s;
        if (push_s && !pop_s) begin
            count_nxt_s = count + CW'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count - CW'(1);
        end else begin
            count_nxt_s = count;
        end
    end

    assign if_ready = !full_s;

    // Control state, ID-side registers and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= {ADDR_WIDTH{1'b0}};
            id_inst  <= {INST_WIDTH{1'b0}};
            count    <= {CW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            overflow <= 1'b0;
        end else if (flush) begin
            // Same as reset except the overflow history is kept.
            id_valid <= 1'b0;
            id_pc    <= {ADDR_WIDTH{1'b0}};
            id_inst  <= {INST_WIDTH{1'b0}};
            count    <= {CW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
        end else begin
            if (advance_s) begin
                if (!empty_s) begin
                    id_valid <= 1'b1;
                    id_pc    <= pc_mem_r[rd_ptr_r];
                    id_inst  <= inst_mem_r[rd_ptr_r];
                end else if (if_valid) begin
                    id_valid <= 1'b1;
                    id_pc    <= if_pc;
                    id_inst  <= if_inst;
                end else begin
                    id_valid <= 1'b0;
                    id_pc    <= {ADDR_WIDTH{1'b0}};
                    id_inst  <= {INST_WIDTH{1'b0}};
                end
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (drop_s) begin
                overflow <= 1'b1;
            end
            count <= count_nxt_s;
        end
    end

    // FIFO storage; data needs no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_s) begin
            pc_mem_r[wr_ptr_r]   <= if_pc;
            inst_mem_r[wr_ptr_r] <= if_inst;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [IW-1:0] if_inst;
    logic          if_ready;
    logic          id_stall;
    logic          id_valid;
    logic [AW-1:0] id_pc;
    logic [IW-1:0] id_inst;
    logic [CW-1:0] count;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: instructions accepted by the stage but not yet shown on ID.
    logic [AW+IW-1:0] pend[$];
    logic             m_valid;
    logic [AW-1:0]    m_pc;
    logic [IW-1:0]    m_inst;
    logic             m_ovf;

    if_id_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .if_ready(if_ready), .id_stall(id_stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mk_inst(input logic [AW-1:0] pc);
        return (pc * 32'd3) ^ 32'h1300_0013;
    endfunction

    // Drive one cycle of stimulus, advance the reference model, then wait
    // until just after the clock edge so outputs can be sampled.
    task automatic step(input logic r, input logic fl, input logic st,
                        input logic v, input logic [AW-1:0] pc);
        int sz;
        rst = r; flush = fl; id_stall = st; if_valid = v;
        if_pc = pc; if_inst = mk_inst(pc);
        sz = pend.size();
        if (r) begin
            pend.delete();
            m_valid = 1'b0; m_pc = '0; m_inst = '0; m_ovf = 1'b0;
        end else if (fl) begin
            pend.delete();
            m_valid = 1'b0; m_pc = '0; m_inst = '0;
        end else begin
            if (!st) begin
                if (sz > 0) begin
                    {m_pc, m_inst} = pend.pop_front();
                    m_valid = 1'b1;
                end else if (v) begin
                    m_pc = pc; m_inst = mk_inst(pc); m_valid = 1'b1;
                end else begin
                    m_pc = '0; m_inst = '0; m_valid = 1'b0;
                end
            end
            if (v && !(!st && sz == 0)) begin
                if (sz < DEPTH) pend.push_back({pc, mk_inst(pc)});
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h104);
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
        n_vec++; if (id_inst !== 32'h0) begin n_err++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL reset_if_ready got %b want 1", if_ready); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_passthrough();
        logic [AW-1:0] exp_pc [3];
        exp_pc = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, exp_pc[i]);
            n_vec++; if (id_valid !== 1'b1 || id_pc !== exp_pc[i] || id_inst !== mk_inst(exp_pc[i])) begin
                n_err++; $display("FAIL bypass_id[%0d] got v=%b pc=%h inst=%h want pc=%h", i, id_valid, id_pc, id_inst, exp_pc[i]); end
            n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL bypass_count[%0d] got %0d want 0", i, count); end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (id_valid !== 1'b0 || id_pc !== 32'h0) begin
            n_err++; $display("FAIL bubble got v=%b pc=%h want v=0 pc=0", id_valid, id_pc); end
    endtask

    task automatic test_stall_fill();
        logic [AW-1:0] exp_pc [4];
        exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, exp_pc[i]);
            n_vec++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin
                n_err++; $display("FAIL stall_hold[%0d] got v=%b pc=%h want v=1 pc=0", i, id_valid, id_pc); end
        end
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", count); end
        n_vec++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL fill_if_ready got %b want 0", if_ready); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            n_vec++; if (id_valid !== 1'b1 || id_pc !== exp_pc[i] || id_inst !== mk_inst(exp_pc[i])) begin
                n_err++; $display("FAIL drain[%0d] got v=%b pc=%h inst=%h want pc=%h", i, id_valid, id_pc, id_inst, exp_pc[i]); end
            n_vec++; if (count !== CW'(3 - i)) begin n_err++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 3 - i); end
        end
    endtask

    task automatic test_overflow_flush();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40 + 32'(4 * i));
        // Pop and a full-time fetch in the same cycle: the fetch is still dropped.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h14);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drop_overflow got %b want 1", overflow); end
        n_vec++; if (count !== 3'd3 || count !== CW'(pend.size())) begin
            n_err++; $display("FAIL drop_count got %0d want 3", count); end
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h50);
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL refill_count got %0d want 4", count); end
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h54);
        n_vec++; if (count !== 3'd0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin
            n_err++; $display("FAIL flush_state got cnt=%0d v=%b pc=%h want 0/0/0", count, id_valid, id_pc); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL flush_overflow got %b want 1", overflow); end
        n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL flush_if_ready got %b want 1", if_ready); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost got v=%b want 0", id_valid); end
    endtask

    task automatic test_push_pop();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h18);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h1C);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h1E);
        n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL pp_pre_count got %0d want 2", count); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
        n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL pp_count got %0d want 2", count); end
        n_vec++; if (id_pc !== 32'h1C) begin n_err++; $display("FAIL pp_head got %h want 0000001c", id_pc); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            n_vec++; if (id_valid !== m_valid || id_pc !== m_pc || id_inst !== m_inst) begin
                n_err++; $display("FAIL pp_drain[%0d] got v=%b pc=%h want v=%b pc=%h", i, id_valid, id_pc, m_valid, m_pc); end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] pc = 32'h1000;
        logic          v;
        logic          st;
        for (int i = 0; i < 60; i++) begin
            v  = 1'($urandom_range(0, 3) != 0);
            st = 1'($urandom_range(0, 1));
            step(1'b0, 1'b0, st, v, pc);
            if (v) pc = pc + 32'd4;
            n_vec++; if (id_valid !== m_valid || id_pc !== m_pc || id_inst !== m_inst
                         || count !== CW'(pend.size()) || overflow !== m_ovf) begin
                n_err++; $display("FAIL rand[%0d] got v=%b pc=%h cnt=%0d ovf=%b want v=%b pc=%h cnt=%0d ovf=%b",
                                  i, id_valid, id_pc, count, overflow, m_valid, m_pc, pend.size(), m_ovf); end
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            n_vec++; if (id_valid !== m_valid || id_pc !== m_pc || count !== CW'(pend.size())) begin
                n_err++; $display("FAIL rand_drain[%0d] got v=%b pc=%h cnt=%0d want v=%b pc=%h cnt=%0d",
                                  i, id_valid, id_pc, count, m_valid, m_pc, pend.size()); end
        end
    endtask

    initial begin
        m_valid = 1'b0; m_pc = '0; m_inst = '0; m_ovf = 1'b0;
        rst = 1'b1; flush = 1'b0; id_stall = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        test_reset();
        test_passthrough();
        test_stall_fill();
        test_overflow_flush();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        test_push_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
